uc_sequencer: RTL and testbench

- Microcode sequencer for the 4-bit register file.
- Holds a small writable microprogram store and steps through it after a start pulse.
- Each REG micro-op drives one instr/imm pair onto the register file's instr/imm inputs.
- Supports jump, timed wait and halt. Reports busy/done to the top-level controller.

---
 rtl/uc_pkg.sv | 30 +++
 rtl/uc_store.sv | 26 ++
 rtl/uc_sequencer.sv | 126 ++++++++++++
 tb/tb_uc_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared encodings for the microcode sequencer.
// Microword: [9:8] kind, [7:4] instr, [3:0] imm.
package uc_pkg;

  localparam int WORD_W = 10;

  localparam logic [3:0] NOP_INSTR = 4'h0;

  typedef enum logic [1:0] {
    KIND_REG  = 2'b00,
    KIND_JMP  = 2'b01,
    KIND_WAIT = 2'b10,
    KIND_HALT = 2'b11
  } kind_e;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    WAIT,
    DONE
  } state_e;

  typedef struct packed {
    kind_e      kind;
    logic [3:0] instr;
    logic [3:0] imm;
  } uword_t;

endpackage

// File: rtl/uc_store.sv
// Microprogram store: 2**PC_W words, synchronous read and write.
// Contents are deliberately left unreset.
module uc_store
  import uc_pkg::*;
#(
  parameter int PC_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PC_W-1:0]   waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [PC_W-1:0]   raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**PC_W];

  // write port and registered read port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/uc_sequencer.sv
// Microcode sequencer driving instr/imm pairs into the register file.
// Optional UC_SINGLE_STEP_EN adds a step input gating FETCH->EXEC.
module uc_sequencer
  import uc_pkg::*;
#(
  parameter int PC_W   = 4,
  parameter int WAIT_W = 4
) (
  input  logic            clk,
  input  logic            grst,
  input  logic            start,
  input  logic            abort,
`ifdef UC_SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [9:0]      prog_data,
  output logic [3:0]      instr_o,
  output logic [3:0]      imm_o,
  output logic            busy,
  output logic            done,
  output logic [PC_W-1:0] pc_o
);

  state_e            state, state_n;
  logic [PC_W-1:0]   pc, pc_n;
  logic [WAIT_W-1:0] cnt, cnt_n;
  logic [WORD_W-1:0] rdata;
  uword_t            word;
  logic              fetch_go;

  assign word = rdata;
  assign pc_o = pc;

`ifdef UC_SINGLE_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  uc_store #(
    .PC_W (PC_W)
  ) u_store (
    .clk   (clk),
    .we    (prog_we && (state == IDLE)),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (rdata)
  );

  // state, pc and wait counter registers
  always_ff @(posedge clk or posedge grst) begin
    if (grst) begin
      state <= IDLE;
      pc    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      cnt   <= cnt_n;
    end
  end

  // next-state, pc update and decoded outputs
  always_comb begin
    state_n = state;
    pc_n    = pc;
    cnt_n   = cnt;
    instr_o = NOP_INSTR;
    imm_o   = '0;
    busy    = (state != IDLE);
    done    = (state == DONE);
    unique case (state)
      IDLE: begin
        if (start) begin
          pc_n    = '0;
          state_n = FETCH;
        end
      end
      FETCH: begin
        if (fetch_go) state_n = EXEC;
      end
      EXEC: begin
        unique case (word.kind)
          KIND_REG: begin
            instr_o = word.instr;
            imm_o   = word.imm;
            pc_n    = pc + 1'b1;
            state_n = FETCH;
          end
          KIND_JMP: begin
            pc_n    = PC_W'(word.imm);
            state_n = FETCH;
          end
          KIND_WAIT: begin
            if (word.imm == 4'd0) begin
              pc_n    = pc + 1'b1;
              state_n = FETCH;
            end else begin
              cnt_n   = WAIT_W'(word.imm);
              state_n = WAIT;
            end
          end
          KIND_HALT: state_n = DONE;
        endcase
      end
      WAIT: begin
        cnt_n = cnt - 1'b1;
        if (cnt == WAIT_W'(1)) begin
          pc_n    = pc + 1'b1;
          state_n = FETCH;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // abort overrides any transition but keeps pc
    if (abort && (state != IDLE)) begin
      state_n = IDLE;
      pc_n    = pc;
    end
  end

endmodule

// File: tb/tb_uc_sequencer.sv
// Scoreboard bench for uc_sequencer: directed programs,
// expected REG/DONE events queued, monitor pops on output.
module tb_uc_sequencer;

  logic       clk = 1'b0;
  logic       grst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       step = 1'b1;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [9:0] prog_data = '0;
  logic [3:0] instr_o;
  logic [3:0] imm_o;
  logic       busy;
  logic       done;
  logic [3:0] pc_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  typedef struct {
    bit         is_done;
    logic [3:0] instr;
    logic [3:0] imm;
    logic [3:0] pc;
    int         at;
  } ev_t;

  ev_t sb[$];

  uc_sequencer #(
    .PC_W   (4),
    .WAIT_W (4)
  ) dut (
    .clk       (clk),
    .grst      (grst),
    .start     (start),
    .abort     (abort),
`ifdef UC_SINGLE_STEP_EN
    .step      (step),
`endif
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .instr_o   (instr_o),
    .imm_o     (imm_o),
    .busy      (busy),
    .done      (done),
    .pc_o      (pc_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [9:0] mw(logic [1:0] k,
                                    logic [3:0] ins,
                                    logic [3:0] imm);
    return {k, ins, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [3:0] a, logic [9:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    t0    = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic push_reg(logic [3:0] ins, logic [3:0] imm,
                          logic [3:0] pc, int rel);
    ev_t e;
    e.is_done = 1'b0;
    e.instr   = ins;
    e.imm     = imm;
    e.pc      = pc;
    e.at      = t0 + rel;
    sb.push_back(e);
  endtask

  task automatic push_done(logic [3:0] pc, int rel);
    ev_t e;
    e.is_done = 1'b1;
    e.instr   = 4'h0;
    e.imm     = 4'h0;
    e.pc      = pc;
    e.at      = t0 + rel;
    sb.push_back(e);
  endtask

  // monitor: any non-NOP output or done pulse consumes one entry
  always @(negedge clk) begin
    if (!grst && (instr_o != 4'h0 || imm_o != 4'h0 || done)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: instr %0h imm %0h done %0b cycle %0d, none expected",
                 instr_o, imm_o, done, cyc);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("ev_done", int'(done), int'(e.is_done));
        chk("ev_instr", int'(instr_o), int'(e.instr));
        chk("ev_imm", int'(imm_o), int'(e.imm));
        chk("ev_pc", int'(pc_o), int'(e.pc));
        chk("ev_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    int n;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pc", int'(pc_o), 0);
    chk("rst_instr", int'(instr_o), 0);
    chk("rst_imm", int'(imm_o), 0);
    tick();
    tick();
    grst = 1'b0;
    tick();

    // two REG ops then HALT
    wr(4'd0, mw(2'b00, 4'h3, 4'h5));
    wr(4'd1, mw(2'b00, 4'h6, 4'h0));
    wr(4'd2, mw(2'b11, 4'h0, 4'h0));
    go();
    push_reg(4'h3, 4'h5, 4'd0, 2);
    push_reg(4'h6, 4'h0, 4'd1, 4);
    push_done(4'd2, 7);
    for (int i = 0; i < 6; i++) tick();
    chk("t1_busy_c7", int'(busy), 1);
    tick();
    chk("t1_busy_c8", int'(busy), 0);
    chk("t1_pc_hold", int'(pc_o), 2);

    // WAIT 3 then HALT; start with abort in IDLE
    wr(4'd0, mw(2'b10, 4'h0, 4'h3));
    wr(4'd1, mw(2'b11, 4'h0, 4'h0));
    abort = 1'b1;
    go();
    abort = 1'b0;
    push_done(4'd1, 8);
    chk("t2_start_wins", int'(busy), 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) n++;
      tick();
    end
    chk("t2_busy_cycles", n, 8);

    // REG/JMP loop, aborted in FETCH of the JMP
    wr(4'd0, mw(2'b00, 4'h1, 4'h2));
    wr(4'd1, mw(2'b01, 4'h0, 4'h0));
    go();
    push_reg(4'h1, 4'h2, 4'd0, 2);
    push_reg(4'h1, 4'h2, 4'd0, 6);
    push_reg(4'h1, 4'h2, 4'd0, 10);
    for (int i = 0; i < 10; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_abort_busy", int'(busy), 0);
    chk("t3_abort_pc", int'(pc_o), 1);
    for (int i = 0; i < 3; i++) tick();
    chk("t3_pc_frozen", int'(pc_o), 1);

    // write while busy is dropped
    wr(4'd0, mw(2'b00, 4'h3, 4'h5));
    wr(4'd1, mw(2'b10, 4'h0, 4'h3));
    wr(4'd2, mw(2'b11, 4'h0, 4'h0));
    go();
    push_reg(4'h3, 4'h5, 4'd0, 2);
    push_done(4'd2, 10);
    for (int i = 0; i < 4; i++) tick();
    wr(4'd0, mw(2'b00, 4'h9, 4'h9));
    for (int i = 0; i < 5; i++) tick();
    chk("t4_run1_idle", int'(busy), 0);
    go();
    push_reg(4'h3, 4'h5, 4'd0, 2);
    push_done(4'd2, 10);
    for (int i = 0; i < 10; i++) tick();
    chk("t4_run2_idle", int'(busy), 0);

    // grst in WAIT with cnt=2
    go();
    push_reg(4'h3, 4'h5, 4'd0, 2);
    for (int i = 0; i < 5; i++) tick();
    chk("t5_pre_pc", int'(pc_o), 1);
    grst = 1'b1;
    #1;
    chk("t5_busy", int'(busy), 0);
    chk("t5_pc", int'(pc_o), 0);
    chk("t5_instr", int'(instr_o), 0);
    chk("t5_done", int'(done), 0);
    tick();
    grst = 1'b0;
    tick();

`ifdef UC_SINGLE_STEP_EN
    wr(4'd0, mw(2'b00, 4'h5, 4'h7));
    wr(4'd1, mw(2'b11, 4'h0, 4'h0));
    step = 1'b0;
    go();
    push_reg(4'h5, 4'h7, 4'd0, 12);
    for (int i = 0; i < 10; i++) begin
      chk("ss_pc_hold", int'(pc_o), 0);
      chk("ss_instr_nop", int'(instr_o), 0);
      tick();
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("ss_one_op_pc", int'(pc_o), 1);
    chk("ss_busy", int'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    step = 1'b1;
    chk("ss_abort", int'(busy), 0);
`endif

    tick();
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
